pwm_meas32: RTL and testbench

PWM_MEAS32 -- requirements
Module: pwm_meas32

---
 rtl/pwm_meas32_pkg.sv | 28 ++
 rtl/pwm_meas_prescaler.sv | 40 ++++
 rtl/pwm_meas32.sv | 174 +++++++++++++++++
 tb/tb_pwm_meas32.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meas32_pkg.sv
// Shared definitions for the PWM period/high-time measurement block.
// Holds the FSM state encoding, counter widths and a saturating add.
package pwm_meas32_pkg;

  localparam int CNT_W = 32;
  localparam int PRE_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } meas_state_e;

  // Adds the tick to a counter value, clamping at all-ones so a very long
  // pulse reads as "at least this long" instead of wrapping to a small value.
  function automatic logic [CNT_W-1:0] sat_add_tick(input logic [CNT_W-1:0] cnt,
                                                    input logic             tick);
    logic [CNT_W-1:0] result;
    if (tick && (cnt != {CNT_W{1'b1}})) begin
      result = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      result = cnt;
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_meas_prescaler.sv
// Clock prescaler: emits a one-cycle tick every PRE+1 enabled clocks.
// The restart input realigns the tick phase to a reference event.
module pwm_meas_prescaler
  import pwm_meas32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [PRE_W-1:0] PRE,
  input  logic             restart,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;

  assign tick = EN & (pcnt_q == PRE);

  // Next prescale count: held at zero when disabled or restarted, wraps on tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (restart || !EN) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_meas32.sv
// PWM measurement unit: synchronizes an external PWM pin, measures period and
// high time in prescaler ticks, and reports completion, timeout and overrun.
module pwm_meas32
  import pwm_meas32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [PRE_W-1:0] PRE,
  input  logic [CNT_W-1:0] TMO,
  input  logic             PWMIN,
  input  logic             MF_CLR,
  input  logic             TOF_CLR,
  input  logic             OVRF_CLR,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH,
  output logic             MF,
  output logic             TOF,
  output logic             OVRF,
  output logic             BUSY
);

  meas_state_e      state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mf_q, mf_d;
  logic             tof_q, tof_d;
  logic             ovrf_q, ovrf_d;

  logic             rise;
  logic             fall;
  logic             tick;
  logic             accept_rise;
  logic             capture;
  logic             timeout;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt_next;

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  pwm_meas_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .EN      (EN),
    .PRE     (PRE),
    .restart (accept_rise),
    .tick    (tick)
  );

  // Two-flop synchronizer followed by a history register for edge detection.
  always_comb begin
    sync1_d = PWMIN;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Measurement FSM: next state, counters and captured results.
  // The timeout compare uses >= so that a count which passes TMO during an
  // edge cycle (edges win over timeout) still terminates on a later tick.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_d      = high_q;
    accept_rise = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    cnt_next    = sat_add_tick(cnt_q, tick);
    tmo_hit     = (TMO != '0) && (cnt_next >= TMO);

    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            accept_rise = 1'b1;
            cnt_d       = '0;
            state_d     = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            hcnt_d  = cnt_next;
            cnt_d   = cnt_next;
            state_d = MEAS_LOW;
          end else if (tmo_hit) begin
            timeout = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_next;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            accept_rise = 1'b1;
            capture     = 1'b1;
            period_d    = cnt_next;
            high_d      = hcnt_q;
            cnt_d       = '0;
            state_d     = MEAS_HIGH;
          end else if (tmo_hit) begin
            timeout = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_next;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as its clear keeps the flag set.
  always_comb begin
    mf_d   = capture | (mf_q & ~MF_CLR);
    tof_d  = timeout | (tof_q & ~TOF_CLR);
    ovrf_d = (capture & mf_q) | (ovrf_q & ~OVRF_CLR);
  end

  // State, counter, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mf_q     <= 1'b0;
      tof_q    <= 1'b0;
      ovrf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mf_q     <= mf_d;
      tof_q    <= tof_d;
      ovrf_q   <= ovrf_d;
    end
  end

  assign PERIOD = period_q;
  assign HIGH   = high_q;
  assign MF     = mf_q;
  assign TOF    = tof_q;
  assign OVRF   = ovrf_q;
  assign BUSY   = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);

endmodule

// File: tb/tb_pwm_meas32.sv
// Directed self-checking bench for pwm_meas32.
module tb_pwm_meas32;

  logic        clk;
  logic        rst_n;
  logic        EN;
  logic [15:0] PRE;
  logic [31:0] TMO;
  logic        PWMIN;
  logic        MF_CLR;
  logic        TOF_CLR;
  logic        OVRF_CLR;
  logic [31:0] PERIOD;
  logic [31:0] HIGH;
  logic        MF;
  logic        TOF;
  logic        OVRF;
  logic        BUSY;

  int check_count;
  int pass_count;

  pwm_meas32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .EN       (EN),
    .PRE      (PRE),
    .TMO      (TMO),
    .PWMIN    (PWMIN),
    .MF_CLR   (MF_CLR),
    .TOF_CLR  (TOF_CLR),
    .OVRF_CLR (OVRF_CLR),
    .PERIOD   (PERIOD),
    .HIGH     (HIGH),
    .MF       (MF),
    .TOF      (TOF),
    .OVRF     (OVRF),
    .BUSY     (BUSY)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a runaway simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n clocks and land 1 unit after the rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the PWM pin at a level for a number of clocks.
  task automatic pwm_phase(input logic level, input int clks);
    PWMIN = level;
    wait_clks(clks);
  endtask

  task automatic pulse_mf_clr();
    MF_CLR = 1'b1;
    wait_clks(1);
    MF_CLR = 1'b0;
  endtask

  // Reset values while rst_n is held low and just after release.
  task automatic test_reset();
    rst_n = 1'b0; EN = 1'b0; PRE = 16'd0; TMO = 32'd0; PWMIN = 1'b0;
    MF_CLR = 1'b0; TOF_CLR = 1'b0; OVRF_CLR = 1'b0;
    wait_clks(3);
    check_count++; if (PERIOD !== 32'd0) $display("[TB] FAIL rst_period: got %0d, expected 0", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd0) $display("[TB] FAIL rst_high: got %0d, expected 0", HIGH); else pass_count++;
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL rst_mf: got %b, expected 0", MF); else pass_count++;
    check_count++; if (TOF !== 1'b0) $display("[TB] FAIL rst_tof: got %b, expected 0", TOF); else pass_count++;
    check_count++; if (OVRF !== 1'b0) $display("[TB] FAIL rst_ovrf: got %b, expected 0", OVRF); else pass_count++;
    check_count++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_busy: got %b, expected 0", BUSY); else pass_count++;
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  // 30 high / 70 low with a tick every clock.
  task automatic test_basic();
    EN = 1'b1; PRE = 16'd0; TMO = 32'd0; PWMIN = 1'b0;
    wait_clks(5);
    pwm_phase(1'b1, 30);
    check_count++; if (BUSY !== 1'b1) $display("[TB] FAIL basic_busy: got %b, expected 1", BUSY); else pass_count++;
    pwm_phase(1'b0, 70);
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL basic_mf_early: got %b, expected 0", MF); else pass_count++;
    pwm_phase(1'b1, 30);
    check_count++; if (HIGH !== 32'd30) $display("[TB] FAIL basic_high: got %0d, expected 30", HIGH); else pass_count++;
    check_count++; if (PERIOD !== 32'd100) $display("[TB] FAIL basic_period: got %0d, expected 100", PERIOD); else pass_count++;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL basic_mf: got %b, expected 1", MF); else pass_count++;
    check_count++; if (OVRF !== 1'b0) $display("[TB] FAIL basic_ovrf: got %b, expected 0", OVRF); else pass_count++;
  endtask

  // Same waveform with a tick every 4 clocks.
  task automatic test_prescaler();
    EN = 1'b0; PWMIN = 1'b0; PRE = 16'd3;
    pulse_mf_clr();
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL pre_mf_clr: got %b, expected 0", MF); else pass_count++;
    wait_clks(4);
    EN = 1'b1;
    wait_clks(5);
    pwm_phase(1'b1, 30);
    pwm_phase(1'b0, 70);
    pwm_phase(1'b1, 30);
    check_count++; if (HIGH !== 32'd7) $display("[TB] FAIL pre_high: got %0d, expected 7", HIGH); else pass_count++;
    check_count++; if (PERIOD !== 32'd25) $display("[TB] FAIL pre_period: got %0d, expected 25", PERIOD); else pass_count++;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL pre_mf: got %b, expected 1", MF); else pass_count++;
  endtask

  // Stuck-high input with TMO=50 ticks.
  task automatic test_timeout();
    EN = 1'b0; PWMIN = 1'b0; PRE = 16'd0; TMO = 32'd50;
    pulse_mf_clr();
    wait_clks(4);
    EN = 1'b1;
    wait_clks(5);
    PWMIN = 1'b1;
    wait_clks(52);
    check_count++; if (TOF !== 1'b0) $display("[TB] FAIL tmo_tof_early: got %b, expected 0", TOF); else pass_count++;
    check_count++; if (BUSY !== 1'b1) $display("[TB] FAIL tmo_busy_before: got %b, expected 1", BUSY); else pass_count++;
    wait_clks(1);
    check_count++; if (TOF !== 1'b1) $display("[TB] FAIL tmo_tof: got %b, expected 1", TOF); else pass_count++;
    check_count++; if (BUSY !== 1'b0) $display("[TB] FAIL tmo_busy_after: got %b, expected 0", BUSY); else pass_count++;
    check_count++; if (PERIOD !== 32'd25) $display("[TB] FAIL tmo_period_kept: got %0d, expected 25", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd7) $display("[TB] FAIL tmo_high_kept: got %0d, expected 7", HIGH); else pass_count++;
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL tmo_mf: got %b, expected 0", MF); else pass_count++;
    wait_clks(10);
    check_count++; if (BUSY !== 1'b0) $display("[TB] FAIL tmo_stays_wait: got %b, expected 0", BUSY); else pass_count++;
    TOF_CLR = 1'b1;
    wait_clks(1);
    TOF_CLR = 1'b0;
    check_count++; if (TOF !== 1'b0) $display("[TB] FAIL tmo_tof_clr: got %b, expected 0", TOF); else pass_count++;
  endtask

  // Back-to-back captures without clearing MF, then clear racing a capture.
  task automatic test_back_to_back();
    EN = 1'b0; PWMIN = 1'b0; PRE = 16'd0; TMO = 32'd0;
    wait_clks(3);
    EN = 1'b1;
    wait_clks(5);
    pwm_phase(1'b1, 30);
    pwm_phase(1'b0, 70);
    pwm_phase(1'b1, 20);
    check_count++; if (PERIOD !== 32'd100) $display("[TB] FAIL b2b_period1: got %0d, expected 100", PERIOD); else pass_count++;
    check_count++; if (OVRF !== 1'b0) $display("[TB] FAIL b2b_ovrf_first: got %b, expected 0", OVRF); else pass_count++;
    pwm_phase(1'b0, 30);
    pwm_phase(1'b1, 20);
    check_count++; if (PERIOD !== 32'd50) $display("[TB] FAIL b2b_period2: got %0d, expected 50", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd20) $display("[TB] FAIL b2b_high2: got %0d, expected 20", HIGH); else pass_count++;
    check_count++; if (OVRF !== 1'b1) $display("[TB] FAIL b2b_ovrf: got %b, expected 1", OVRF); else pass_count++;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL b2b_mf: got %b, expected 1", MF); else pass_count++;
    pwm_phase(1'b0, 40);
    // Pin rises now; the capture is decided in the third cycle, where MF_CLR is raised.
    PWMIN = 1'b1;
    wait_clks(2);
    MF_CLR = 1'b1;
    wait_clks(1);
    MF_CLR = 1'b0;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL b2b_mf_set_wins: got %b, expected 1", MF); else pass_count++;
    check_count++; if (PERIOD !== 32'd60) $display("[TB] FAIL b2b_period3: got %0d, expected 60", PERIOD); else pass_count++;
    wait_clks(17);
    OVRF_CLR = 1'b1;
    wait_clks(1);
    OVRF_CLR = 1'b0;
    check_count++; if (OVRF !== 1'b0) $display("[TB] FAIL b2b_ovrf_clr: got %b, expected 0", OVRF); else pass_count++;
  endtask

  // Drop EN during the low phase; results and flags are kept, partial period discarded.
  task automatic test_en_drop();
    pwm_phase(1'b0, 20);
    EN = 1'b0;
    wait_clks(3);
    check_count++; if (BUSY !== 1'b0) $display("[TB] FAIL en_busy: got %b, expected 0", BUSY); else pass_count++;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL en_mf_kept: got %b, expected 1", MF); else pass_count++;
    check_count++; if (PERIOD !== 32'd60) $display("[TB] FAIL en_period_kept: got %0d, expected 60", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd20) $display("[TB] FAIL en_high_kept: got %0d, expected 20", HIGH); else pass_count++;
    EN = 1'b1;
    pulse_mf_clr();
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL en_mf_clr: got %b, expected 0", MF); else pass_count++;
    wait_clks(5);
    pwm_phase(1'b1, 30);
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL en_no_broken_mf: got %b, expected 0", MF); else pass_count++;
    pwm_phase(1'b0, 70);
    pwm_phase(1'b1, 10);
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL en_fresh_mf: got %b, expected 1", MF); else pass_count++;
    check_count++; if (PERIOD !== 32'd100) $display("[TB] FAIL en_fresh_period: got %0d, expected 100", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd30) $display("[TB] FAIL en_fresh_high: got %0d, expected 30", HIGH); else pass_count++;
  endtask

  // Asynchronous reset in the middle of a low phase, then a clean restart.
  task automatic test_reset_mid();
    pwm_phase(1'b0, 20);
    #2 rst_n = 1'b0;
    #2;
    check_count++; if (PERIOD !== 32'd0) $display("[TB] FAIL arst_period: got %0d, expected 0", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd0) $display("[TB] FAIL arst_high: got %0d, expected 0", HIGH); else pass_count++;
    check_count++; if ({MF, TOF, OVRF, BUSY} !== 4'b0000) $display("[TB] FAIL arst_flags: got %b, expected 0000", {MF, TOF, OVRF, BUSY}); else pass_count++;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_clks(5);
    pwm_phase(1'b1, 40);
    check_count++; if (MF !== 1'b0) $display("[TB] FAIL arst_no_stale_mf: got %b, expected 0", MF); else pass_count++;
    pwm_phase(1'b0, 60);
    pwm_phase(1'b1, 10);
    check_count++; if (PERIOD !== 32'd100) $display("[TB] FAIL arst_period_new: got %0d, expected 100", PERIOD); else pass_count++;
    check_count++; if (HIGH !== 32'd40) $display("[TB] FAIL arst_high_new: got %0d, expected 40", HIGH); else pass_count++;
    check_count++; if (MF !== 1'b1) $display("[TB] FAIL arst_mf_new: got %b, expected 1", MF); else pass_count++;
    check_count++; if (OVRF !== 1'b0) $display("[TB] FAIL arst_ovrf_new: got %b, expected 0", OVRF); else pass_count++;
  endtask

  // Scenario sequence.
  initial begin
    check_count = 0;
    pass_count  = 0;
    test_reset();
    test_basic();
    test_prescaler();
    test_timeout();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
